// File: rtl/ddls_tap_encoder.sv
// ddls_tap_encoder: one-hot tap vector to binary delay code with sync, one-hot check, stability filter and valid/ready output
module ddls_tap_encoder #(
    parameter int BUFFERSIZE = 4,
    parameter int OUTPUTSIZE = 2,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [BUFFERSIZE-1:0] tap_in,
    output logic [OUTPUTSIZE-1:0] code_out,
    output logic                  code_valid,
    input  logic                  code_ready,
    output logic                  err_onehot,
    output logic [7:0]            err_count
);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam logic [SW-1:0] SC = SW'(STABLE_CNT);

    typedef enum logic [1:0] {DISABLED, ACQUIRE, OFFER} state_t;

    state_t                  state_q, state_d;
    logic [BUFFERSIZE-1:0]   s1_q, s2_q;
    logic [SW-1:0]           stab_q, stab_d;
    logic [OUTPUTSIZE-1:0]   cand_q, cand_d, last_q, last_d, code_q, code_d, idx;
    logic                    pub_any_q, pub_any_d, valid_q, valid_d, err_q, err_d, one_hot;
    logic [7:0]              cnt_q, cnt_d;

    always_comb begin
        idx = '0;
        for (int i = 0; i < BUFFERSIZE; i++)
            if (s2_q[i]) idx = OUTPUTSIZE'(i);
        one_hot = (s2_q != '0) && ((s2_q & (s2_q - BUFFERSIZE'(1))) == '0);
    end

    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        cand_d    = cand_q;
        last_d    = last_q;
        pub_any_d = pub_any_q;
        code_d    = code_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            DISABLED: begin
                stab_d = '0;
                cand_d = '0;
                state_d = en ? ACQUIRE : DISABLED;
            end
            ACQUIRE: begin
                if (!en) begin
                    state_d = DISABLED;
                    stab_d  = '0;
                    cand_d  = '0;
                end else if (!one_hot) begin
                    err_d  = 1'b1;
                    cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    stab_d = '0;
                end else begin
                    stab_d = (idx != cand_q) ? SW'(1) : (stab_q == SC) ? SC : stab_q + SW'(1);
                    cand_d = idx;
                    // a code equal to the last published one is only offered once
                    if (stab_d == SC && (cand_d != last_q || !pub_any_q)) begin
                        code_d    = cand_d;
                        last_d    = cand_d;
                        pub_any_d = 1'b1;
                        valid_d   = 1'b1;
                        state_d   = OFFER;
                    end
                end
            end
            OFFER: begin
                if (code_ready) begin
                    valid_d = 1'b0;
                    state_d = en ? ACQUIRE : DISABLED;
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DISABLED;
            s1_q      <= '0;
            s2_q      <= '0;
            stab_q    <= '0;
            cand_q    <= '0;
            last_q    <= '0;
            pub_any_q <= 1'b0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= tap_in;
            s2_q      <= s1_q;
            stab_q    <= stab_d;
            cand_q    <= cand_d;
            last_q    <= last_d;
            pub_any_q <= pub_any_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign err_onehot = err_q;
    assign err_count  = cnt_q;
endmodule

// File: tb/tb_ddls_tap_encoder.sv
// tb_ddls_tap_encoder: randomized and directed stimulus, behavioural model feeding a publish scoreboard
module tb_ddls_tap_encoder;
    localparam int SC = 3;
    localparam int M_DIS = 0, M_ACQ = 1, M_OFF = 2;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, code_ready = 1'b0;
    logic [3:0] tap_in = 4'b0000;
    logic [1:0] code_out;
    logic       code_valid, err_onehot;
    logic [7:0] err_count;

    int n_tests = 0, n_fail = 0;
    int m_mode = M_DIS, m_stab = 0, m_cand = 0, m_last = 0, m_code = 0, m_cnt = 0;
    bit m_any = 0, m_valid = 0, m_err = 0;
    logic [3:0] m_s1 = 4'b0000, m_s2 = 4'b0000;
    int exp_q[$];

    ddls_tap_encoder #(.BUFFERSIZE(4), .OUTPUTSIZE(2), .STABLE_CNT(SC)) dut (
        .clk(clk), .rst(rst), .en(en), .tap_in(tap_in),
        .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
        .err_onehot(err_onehot), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // reference model: spec rules with plain integers, one step per clock edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_DIS; m_stab = 0; m_cand = 0; m_last = 0; m_code = 0; m_cnt = 0;
            m_any = 0; m_valid = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
            exp_q.delete();
        end else begin
            m_err = 0;
            if (m_mode == M_DIS) begin
                m_stab = 0; m_cand = 0;
                if (en) m_mode = M_ACQ;
            end else if (m_mode == M_ACQ) begin
                if (!en) begin
                    m_mode = M_DIS; m_stab = 0; m_cand = 0;
                end else if ($countones(m_s2) != 1) begin
                    m_err = 1; m_stab = 0;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    if ($clog2(m_s2) == m_cand) m_stab = (m_stab + 1 > SC) ? SC : m_stab + 1;
                    else begin m_cand = $clog2(m_s2); m_stab = 1; end
                    if (m_stab == SC && (m_cand != m_last || !m_any)) begin
                        m_code = m_cand; m_last = m_cand; m_any = 1; m_valid = 1; m_mode = M_OFF;
                        exp_q.push_back(m_cand);
                    end
                end
            end else if (code_ready) begin
                m_valid = 0;
                m_mode = en ? M_ACQ : M_DIS;
            end
            m_s2 = m_s1;
            m_s1 = tap_in;
        end
    end

    // monitor: compares every cycle and pops the scoreboard on each transfer
    always @(negedge clk) begin
        if (!rst) begin
            chk("code_valid", code_valid, m_valid);
            chk("code_out", code_out, m_code);
            chk("err_onehot", err_onehot, m_err);
            chk("err_count", err_count, m_cnt);
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) chk("unexpected_publish", code_out, -1);
                else chk("xfer_code", code_out, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic [3:0] t, input logic e, input logic r);
        @(posedge clk);
        #2;
        tap_in = t; en = e; code_ready = r;
    endtask

    logic [3:0] seq [6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] cur, t;
    int r;

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_code_valid", code_valid, 0);
        chk("rst_err_count", err_count, 0);
        repeat (2) step(4'b0000, 0, 0);
        repeat (10) step(4'b0100, 1, 1);
        repeat (8) step(4'b0010, 1, 0);
        repeat (10) step(4'b1000, 1, 0);
        repeat (8) step(4'b1000, 1, 1);
        foreach (seq[i]) step(seq[i], 1, 1);
        repeat (6) step(4'b0001, 1, 1);
        repeat (3) step(4'b0110, 1, 1);
        step(4'b0000, 1, 1);
        repeat (6) step(4'b0001, 1, 1);
        repeat (300) step(4'b0011, 1, 1);
        @(negedge clk);
        chk("err_saturate", err_count, 255);
        repeat (6) step(4'b0100, 1, 0);
        repeat (4) step(4'b0100, 0, 0);
        repeat (6) step(4'b0100, 0, 1);
        repeat (8) step(4'b0001, 1, 0);
        chk("offer_before_rst", code_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", code_valid, 0);
        chk("async_rst_code", code_out, 0);
        chk("async_rst_err", err_onehot, 0);
        chk("async_rst_count", err_count, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) step(4'b0001, 1, 1);
        cur = 4'b0001;
        repeat (3000) begin
            r = $urandom_range(0, 99);
            if (r < 10) cur = 4'(1) << $urandom_range(0, 3);
            t = (r >= 95) ? 4'($urandom_range(0, 15)) : cur;
            step(t, $urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0);
        end
        repeat (10) step(cur, 0, 1);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
